dsi_cmd_video_sched: RTL and testbench

- Scheduler for the HS data lanes of the DSI transmit path, in the tx_byte_clk domain.
- Sits between the HS packetizer output (hs_en/hs_data) and lp_hs_delay_ctrl.
- Passes the video stream through with absolute priority.
- Queues DCS/generic short-write commands (for example brightness or display on/off after lcm_init_done) and inserts each as its own HS burst during vertical blanking gaps. Computes ECC and optionally appends EoTp.

---
 rtl/dsi_cmd_video_sched.sv | 172 +++++++++++++++++
 tb/tb_dsi_cmd_video_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_cmd_video_sched.sv
// HS lane scheduler for the DSI transmit path: video passes straight through,
// queued DCS short writes are sent as their own HS bursts in long blanking gaps.
module dsi_cmd_video_sched #(
    parameter int CMD_DEPTH = 8,
    parameter int GAP_MIN   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eotp_en,
    input  logic        vid_blank,
    input  logic        vid_hs_en,
    input  logic [31:0] vid_hs_data,
    input  logic        cmd_wr,
    input  logic [23:0] cmd_wdata,
    output logic        cmd_full,
    output logic [4:0]  cmd_level,
    output logic        hs_en,
    output logic [31:0] hs_data,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic [1:0]  err,
    input  logic        err_clr
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int GW = $clog2(GAP_MIN + 1);
    localparam logic [4:0]    DEPTH_L   = 5'(CMD_DEPTH);
    localparam logic [GW-1:0] GAP_L     = GW'(GAP_MIN);
    localparam logic [31:0]   EOTP_WORD = 32'h010F0F08;

    typedef enum logic [1:0] {IDLE = 2'd0, CMD_HDR = 2'd1, CMD_EOT = 2'd2} state_t;

    // DSI packet header ECC: 6-bit Hamming parity over {data1, data0, DI}
    function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    logic [23:0]   mem_r [CMD_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [4:0]    level_r;
    logic [GW-1:0] guard_r;
    state_t        state_r, state_s;
    logic          eot_sel_r;
    logic          hs_en_r, busy_r, done_r;
    logic [31:0]   hs_data_r;
    logic [1:0]    err_r;
    logic          full_s, push_s, pop_s, collide_s, out_en_s;
    logic [31:0]   out_data_s;
    logic [23:0]   head_s;

    assign full_s    = (level_r == DEPTH_L);
    assign push_s    = cmd_wr & ~full_s;
    assign head_s    = mem_r[rd_ptr_r];
    assign cmd_full  = full_s;
    assign cmd_level = level_r;
    assign hs_en     = hs_en_r;
    assign hs_data   = hs_data_r;
    assign cmd_busy  = busy_r;
    assign cmd_done  = done_r;
    assign err       = err_r;

    // Next state and next output word; video always takes the lane when present
    always_comb begin
        state_s    = state_r;
        pop_s      = 1'b0;
        collide_s  = 1'b0;
        out_en_s   = vid_hs_en;
        out_data_s = vid_hs_data;
        case (state_r)
            IDLE: begin
                if ((guard_r == GAP_L) && (level_r != 5'd0) && !vid_hs_en) begin
                    state_s    = CMD_HDR;
                    out_en_s   = 1'b1;
                    out_data_s = {dsi_ecc(head_s), head_s};
                end else begin
                    state_s = IDLE;
                end
            end
            CMD_HDR: begin
                if (vid_hs_en) begin
                    collide_s = 1'b1;
                    state_s   = IDLE;
                end else if (eot_sel_r) begin
                    state_s    = CMD_EOT;
                    out_en_s   = 1'b1;
                    out_data_s = EOTP_WORD;
                end else begin
                    state_s = IDLE;
                    pop_s   = 1'b1;
                end
            end
            CMD_EOT: begin
                if (vid_hs_en) begin
                    collide_s = 1'b1;
                end else begin
                    pop_s = 1'b1;
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, EoTp selection and guard; guard is held at zero around a burst so gaps restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            eot_sel_r <= 1'b0;
            guard_r   <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE && state_s == CMD_HDR) begin
                eot_sel_r <= eotp_en;
            end
            if (state_r != IDLE || state_s != IDLE || !vid_blank || vid_hs_en) begin
                guard_r <= '0;
            end else if (guard_r < GAP_L) begin
                guard_r <= guard_r + GW'(1);
            end
        end
    end

    // Command storage (data only; validity is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cmd_wdata;
        end
    end

    // FIFO pointers, occupancy and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= 5'd0;
            err_r    <= 2'b00;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 5'd1;
                2'b01:   level_r <= level_r - 5'd1;
                default: level_r <= level_r;
            endcase
            err_r[0] <= (err_r[0] & ~err_clr) | collide_s;
            err_r[1] <= (err_r[1] & ~err_clr) | (cmd_wr & full_s);
        end
    end

    // Registered lane outputs and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_en_r   <= 1'b0;
            hs_data_r <= 32'h0000_0000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            hs_en_r   <= out_en_s;
            hs_data_r <= out_data_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= pop_s;
        end
    end
endmodule

// File: tb/tb_dsi_cmd_video_sched.sv
// Randomized and directed bench for dsi_cmd_video_sched against a queue-based
// model of the lane: a command queue, a run length of idle blanking and a burst word list.
module tb_dsi_cmd_video_sched;
    localparam int DEPTH = 8;
    localparam int GAP   = 64;

    logic        clk = 1'b0;
    logic        rst_n, eotp_en, vid_blank, vid_hs_en, cmd_wr, err_clr;
    logic [31:0] vid_hs_data;
    logic [23:0] cmd_wdata;
    logic        cmd_full, hs_en, cmd_busy, cmd_done;
    logic [4:0]  cmd_level;
    logic [31:0] hs_data;
    logic [1:0]  err;

    dsi_cmd_video_sched #(.CMD_DEPTH(DEPTH), .GAP_MIN(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .eotp_en(eotp_en), .vid_blank(vid_blank),
        .vid_hs_en(vid_hs_en), .vid_hs_data(vid_hs_data), .cmd_wr(cmd_wr),
        .cmd_wdata(cmd_wdata), .cmd_full(cmd_full), .cmd_level(cmd_level),
        .hs_en(hs_en), .hs_data(hs_data), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] m_q[$];
    logic [31:0] m_burst[$];
    int          m_run;
    logic [1:0]  m_err;
    logic        e_en, e_done, e_busy;
    logic [31:0] e_data;

    // Syndrome column of each header bit in the DSI ECC code
    function automatic logic [5:0] ecc_col(input int i);
        case (i)
            0: return 6'h07;  1: return 6'h0B;  2: return 6'h0D;  3: return 6'h0E;
            4: return 6'h13;  5: return 6'h15;  6: return 6'h16;  7: return 6'h19;
            8: return 6'h1A;  9: return 6'h1C; 10: return 6'h23; 11: return 6'h25;
           12: return 6'h26; 13: return 6'h29; 14: return 6'h2A; 15: return 6'h2C;
           16: return 6'h31; 17: return 6'h32; 18: return 6'h34; 19: return 6'h38;
           20: return 6'h1F; 21: return 6'h2F; 22: return 6'h37; 23: return 6'h3B;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [7:0] ref_ecc(input logic [23:0] h);
        logic [5:0] p = 6'h00;
        for (int i = 0; i < 24; i++) if (h[i]) p ^= ecc_col(i);
        return {2'b00, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_burst.delete();
        m_run  = 0;
        m_err  = 2'b00;
        e_en   = 1'b0;
        e_data = 32'h0;
        e_done = 1'b0;
        e_busy = 1'b0;
    endtask

    // Predict the registered outputs produced by the coming clock edge
    task automatic model_step();
        logic was_busy, full, start, collide, done;
        was_busy = (m_burst.size() > 0);
        full     = (m_q.size() == DEPTH);
        start    = 1'b0;
        collide  = 1'b0;
        done     = 1'b0;
        e_en     = vid_hs_en;
        e_data   = vid_hs_data;
        if (was_busy) begin
            if (vid_hs_en) begin
                collide = 1'b1;
                m_burst.delete();
            end else begin
                m_burst.delete(0);
                if (m_burst.size() == 0) begin
                    done = 1'b1;
                end else begin
                    e_en   = 1'b1;
                    e_data = m_burst[0];
                end
            end
        end else if (m_run >= GAP && m_q.size() > 0 && !vid_hs_en) begin
            start = 1'b1;
            m_burst.push_back({ref_ecc(m_q[0]), m_q[0]});
            if (eotp_en) m_burst.push_back(32'h010F0F08);
            e_en   = 1'b1;
            e_data = m_burst[0];
        end
        if (was_busy || start || !vid_blank || vid_hs_en) m_run = 0;
        else if (m_run < GAP) m_run++;
        if (done) m_q.delete(0);
        if (cmd_wr && !full) m_q.push_back(cmd_wdata);
        m_err[0] = (m_err[0] & ~err_clr) | collide;
        m_err[1] = (m_err[1] & ~err_clr) | (cmd_wr & full);
        e_done   = done;
        e_busy   = (m_burst.size() > 0);
    endtask

    task automatic check_all();
        chk("hs_en", 32'(hs_en), 32'(e_en));
        chk("hs_data", hs_data, e_data);
        chk("cmd_done", 32'(cmd_done), 32'(e_done));
        chk("cmd_busy", 32'(cmd_busy), 32'(e_busy));
        chk("err", 32'(err), 32'(m_err));
        chk("cmd_level", 32'(cmd_level), 32'(m_q.size()));
        chk("cmd_full", 32'(cmd_full), 32'(m_q.size() == DEPTH));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        cmd_wr      = 1'b0;
        err_clr     = 1'b0;
        vid_hs_data = $urandom;
    endtask

    task automatic push(input logic [23:0] c);
        cmd_wr    = 1'b1;
        cmd_wdata = c;
        step();
    endtask

    initial begin
        int seg, mode;
        logic seen;
        rst_n = 1'b0; eotp_en = 1'b0; vid_blank = 1'b0; vid_hs_en = 1'b0;
        vid_hs_data = 32'h0; cmd_wr = 1'b0; cmd_wdata = 24'h0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // pass-through of a 10-word video burst with an empty queue
        for (int i = 0; i < 10; i++) begin
            vid_hs_en = 1'b1; vid_hs_data = 32'(i); model_step();
            @(posedge clk); #1; check_all();
        end
        vid_hs_en = 1'b0;
        repeat (3) step();

        // single command with EoTp in one long blanking gap
        eotp_en = 1'b1;
        push(24'h001105);
        vid_blank = 1'b1;
        repeat (GAP + 8) step();

        // two commands without EoTp, separated by a restarted guard
        vid_blank = 1'b0; eotp_en = 1'b0;
        push(24'h002905);
        push(24'h001105);
        vid_blank = 1'b1;
        repeat (2 * GAP + 12) step();

        // blanking one cycle too short before video: command must stay queued
        vid_blank = 1'b0;
        push(24'($urandom));
        vid_blank = 1'b1;
        repeat (GAP - 1) step();
        vid_blank = 1'b0;
        vid_hs_en = 1'b1;
        repeat (6) step();
        vid_hs_en = 1'b0;
        repeat (4) step();

        // collision in the header cycle, then retry in the next gap
        vid_blank = 1'b1; eotp_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3 * GAP && !seen; i++) begin
            step();
            seen = (m_burst.size() == 2);
        end
        chk("collision_setup", 32'(seen), 32'd1);
        vid_hs_en = 1'b1;
        step();
        vid_hs_en = 1'b0;
        repeat (GAP + 8) step();
        err_clr = 1'b1;
        step();

        // randomized traffic: alternating blanking and video segments
        seg = 0; mode = 0;
        for (int i = 0; i < 2500; i++) begin
            if (seg == 0) begin
                mode = 1 - mode;
                seg  = (mode == 1) ? int'($urandom_range(20, 160)) : int'($urandom_range(8, 60));
            end
            seg--;
            vid_blank = (mode == 1);
            vid_hs_en = (mode == 1) ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) != 0);
            eotp_en   = $urandom_range(0, 1) == 1;
            cmd_wr    = $urandom_range(0, 11) == 0;
            cmd_wdata = 24'($urandom);
            err_clr   = $urandom_range(0, 63) == 0;
            step();
        end

        // overflow, then asynchronous reset during the EoTp word
        vid_blank = 1'b0; vid_hs_en = 1'b0; eotp_en = 1'b1;
        repeat (3) step();
        err_clr = 1'b1;
        step();
        for (int i = 0; i < DEPTH && m_q.size() < DEPTH; i++) push(24'($urandom));
        push(24'($urandom));
        vid_blank = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3 * GAP && !seen; i++) begin
            step();
            seen = (m_burst.size() == 1);
        end
        chk("eot_setup", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        vid_blank = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
